// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size codes (also used by the
// decoder), LSU state encoding and small size-decoding helpers.
package riscv_pkg;

  // Load/store size codes as produced by the decoder
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // LSU sequencing states
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Access width after folding signed/unsigned variants together
  typedef enum logic [1:0] {
    ACC_B = 2'd0,
    ACC_H = 2'd1,
    ACC_W = 2'd2
  } acc_width_e;

  // Unused size codes (3, 6, 7) behave as a word access
  function automatic acc_width_e size_width(input logic [2:0] size);
    acc_width_e w;
    case (size)
      LDST_B, LDST_BU: w = ACC_B;
      LDST_H, LDST_HU: w = ACC_H;
      default:         w = ACC_W;
    endcase
    return w;
  endfunction

  // Only B and H loads sign-extend
  function automatic logic size_signed(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_H);
  endfunction

  // Halfwords need a[0]=0, words need a[1:0]=0
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size_width(size))
      ACC_H:   mis = addr_lo[0];
      ACC_W:   mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational data formatting for the LSU: byte enables, store-data
// replication and load-data extraction with sign/zero extension.
// Low address bits below the natural alignment of the access are ignored.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data
);

  acc_width_e  width;
  logic        sgn;
  logic [1:0]  offset;
  logic [31:0] shifted;

  // Select lane offset, enables and replicated store data, then extract load data
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    width     = size_width(size);
    sgn       = size_signed(size);
    offset    = 2'b00;
    be        = 4'b1111;
    bus_wdata = store_data;
    load_data = 32'd0;
    case (width)
      ACC_B: begin
        offset    = addr_lo;
        be        = 4'b0001 << offset;
        bus_wdata = {4{store_data[7:0]}};
      end
      ACC_H: begin
        offset    = {addr_lo[1], 1'b0};
        be        = 4'b0011 << offset;
        bus_wdata = {2{store_data[15:0]}};
      end
      default: begin
        offset    = 2'b00;
        be        = 4'b1111;
        bus_wdata = store_data;
      end
    endcase
    shifted = bus_rdata >> {offset, 3'b000};
    case (width)
      ACC_B:   load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
      ACC_H:   load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit controller: sequences one data-memory transaction per
// instruction over a req/gnt/rvalid bus and stalls the pipeline meanwhile.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W
// accesses (no bus request, misalign_o pulse) instead of truncating them.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  // Counter value in the last cycle allowed before the timeout fires
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [7:0]  cnt_q;
  logic        bus_err_q;
  logic [31:0] lsu_data_q;
  logic        accept;
  logic        misaligned;
  logic        timeout;
  logic        err_set;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;

  assign accept  = (state_q == LSU_IDLE) && lsu_req_i;
  assign timeout = (cnt_q >= TIMEOUT_LAST);

  // A handshake in the final allowed cycle still wins over the timeout
  assign err_set = ((state_q == LSU_REQ)  && !data_gnt_i    && timeout) ||
                   ((state_q == LSU_WAIT) && !data_rvalid_i && timeout);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misaligned = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);

  // Flag the trapped access so misalign_o pulses during its DONE cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= accept && misaligned;
  end

  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Next-state logic of the transaction sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (lsu_req_i) state_d = misaligned ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (data_gnt_i) state_d = LSU_WAIT;
                else if (timeout) state_d = LSU_DONE;
      LSU_WAIT: if (data_rvalid_i || timeout) state_d = LSU_DONE;
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // State register, request latch, timeout counter and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q    <= LSU_IDLE;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      cnt_q      <= 8'd0;
      bus_err_q  <= 1'b0;
      lsu_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= err_set;
      if (accept) begin
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
        addr_q  <= lsu_addr_i;
        sdata_q <= lsu_data_i;
      end
      if ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) cnt_q <= cnt_q + 8'd1;
      else                                               cnt_q <= 8'd0;
      if ((state_q == LSU_WAIT) && data_rvalid_i && !we_q) lsu_data_q <= fmt_load;
      else if (err_set)                                    lsu_data_q <= 32'd0;
    end
  end

  riscv_lsu_align u_align (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (sdata_q),
    .bus_rdata  (data_rdata_i),
    .be         (fmt_be),
    .bus_wdata  (fmt_wdata),
    .load_data  (fmt_load)
  );

  // Bus fields are only driven while requesting, so reset leaves them at zero
  assign data_req_o   = (state_q == LSU_REQ);
  assign data_we_o    = data_req_o && we_q;
  assign data_be_o    = data_req_o ? fmt_be : 4'b0000;
  assign data_addr_o  = data_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
  assign data_wdata_o = data_req_o ? fmt_wdata : 32'd0;

  assign lsu_stall_o  = accept || (state_q == LSU_REQ) || (state_q == LSU_WAIT);
  assign bus_err_o    = bus_err_q;
  assign lsu_data_o   = lsu_data_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu (MEM_TIMEOUT=8): directed scenarios plus
// randomized back-to-back accesses against a byte-level reference model.
module tb_riscv_lsu;

  localparam int unsigned TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'd0;
  logic [31:0] lsu_addr_i = 32'd0;
  logic [31:0] lsu_data_i = 32'd0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_o;
  logic        bus_err_o;
  logic        misalign_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'd0;

  riscv_lsu #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lsu_req_i     (lsu_req_i),
    .lsu_we_i      (lsu_we_i),
    .lsu_size_i    (lsu_size_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_data_i    (lsu_data_i),
    .lsu_data_o    (lsu_data_o),
    .lsu_stall_o   (lsu_stall_o),
    .bus_err_o     (bus_err_o),
    .misalign_o    (misalign_o),
    .data_req_o    (data_req_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the architecturally visible load result register
  logic [31:0] exp_lsu_data = 32'd0;

  // Observations from the last access
  int          obs_stall;
  int          obs_req_cycles;
  bit          obs_done;
  bit          obs_req_seen;
  bit          obs_err;
  bit          obs_mis;
  int          obs_spurious;
  logic [31:0] obs_data;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic        obs_we;

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int nbytes(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 1;
    if (s == 3'd1 || s == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit trapped(input logic [2:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (a % nbytes(s)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    return 4'(((1 << n) - 1) << lane(s, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] d);
    int n = nbytes(s);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] r);
    int n = nbytes(s);
    logic [31:0] v = r >> (8 * lane(s, a));
    bit sgn = (s == 3'd0) || (s == 3'd1);
    if (n == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v - 32'h100;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v - 32'h1_0000;
    end
    return v;
  endfunction

  // ---------------- bus driver for one access ----------------
  // gnt_delay < 0 means the grant is never given.
  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int gnt_delay, input int rv_delay);
    bit granted = 0;
    int wait_n = 0;
    obs_stall = 0; obs_req_cycles = 0; obs_done = 0; obs_req_seen = 0;
    obs_err = 0; obs_mis = 0; obs_spurious = 0; obs_data = 'x;
    obs_be = 'x; obs_addr = 'x; obs_wdata = 'x; obs_we = 'x;
    @(posedge clk_i); #1;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
    lsu_addr_i = addr; lsu_data_i = wdata;
    #1;
    if (lsu_stall_o) obs_stall++;
    for (int cyc = 0; cyc < 40 && !obs_done; cyc++) begin
      @(posedge clk_i); #1;
      if (data_gnt_i) granted = 1;
      lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
      data_rdata_i = $urandom;
      #1;
      if (!lsu_stall_o) begin
        obs_done = 1; obs_data = lsu_data_o; obs_err = bus_err_o; obs_mis = misalign_o;
        if (data_req_o) obs_spurious++;
      end else begin
        obs_stall++;
        if (bus_err_o || misalign_o) obs_spurious++;
        if (data_req_o) begin
          if (!obs_req_seen) begin
            obs_be = data_be_o; obs_addr = data_addr_o;
            obs_wdata = data_wdata_o; obs_we = data_we_o;
          end
          obs_req_seen = 1;
          if (gnt_delay >= 0 && obs_req_cycles == gnt_delay) data_gnt_i = 1'b1;
          obs_req_cycles++;
        end else if (granted) begin
          if (wait_n == rv_delay) begin
            data_rvalid_i = 1'b1; data_rdata_i = rdata;
          end
          wait_n++;
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    #3;
    n_cmp++;
    if ({lsu_data_o, lsu_stall_o, bus_err_o, misalign_o, data_req_o, data_we_o,
         data_be_o, data_addr_o, data_wdata_o} !== 105'd0) begin
      n_bad++; $display("FAIL reset_outputs: got stall=%b req=%b data=%h be=%b addr=%h, want all 0",
                        lsu_stall_o, data_req_o, lsu_data_o, data_be_o, data_addr_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_lsu_data = 32'd0;
  endtask

  task automatic test_lw_best_case();
    run_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    exp_lsu_data = 32'hDEAD_BEEF;
    n_cmp++;
    if (!obs_done || obs_stall != 3) begin
      n_bad++; $display("FAIL lw_stall_cycles: got %0d (done=%0b), want 3", obs_stall, obs_done);
    end
    n_cmp++;
    if (obs_data !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL lw_data: got %h, want deadbeef", obs_data);
    end
    n_cmp++;
    if (obs_be !== 4'b1111 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
      n_bad++; $display("FAIL lw_bus: got be=%b addr=%h we=%b, want 1111 00000100 0",
                        obs_be, obs_addr, obs_we);
    end
  endtask

  task automatic test_lb_lbu();
    run_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
    n_cmp++;
    if (obs_be !== 4'b1000 || obs_data !== 32'hFFFF_FF80) begin
      n_bad++; $display("FAIL lb_signed: got be=%b data=%h, want 1000 ffffff80", obs_be, obs_data);
    end
    run_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 1, 2);
    exp_lsu_data = 32'h0000_0080;
    n_cmp++;
    if (obs_be !== 4'b1000 || obs_data !== 32'h0000_0080 || obs_stall != 6) begin
      n_bad++; $display("FAIL lbu_unsigned: got be=%b data=%h stall=%0d, want 1000 00000080 6",
                        obs_be, obs_data, obs_stall);
    end
  endtask

  task automatic test_sh();
    run_access(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0);
    n_cmp++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_addr !== 32'h200 || obs_we !== 1'b1) begin
      n_bad++; $display("FAIL sh_bus: got be=%b wdata=%h addr=%h we=%b, want 1100 abcdabcd 00000200 1",
                        obs_be, obs_wdata, obs_addr, obs_we);
    end
    n_cmp++;
    if (obs_data !== exp_lsu_data) begin
      n_bad++; $display("FAIL sh_keeps_load_data: got %h, want %h", obs_data, exp_lsu_data);
    end
  endtask

  task automatic test_misaligned_lw();
    run_access(1'b0, 3'd2, 32'h101, 32'h0, 32'h0BAD_F00D, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++;
    if (obs_req_seen || obs_mis !== 1'b1 || obs_stall != 1 || obs_data !== exp_lsu_data) begin
      n_bad++; $display("FAIL misalign_trap: got req=%0b mis=%b stall=%0d data=%h, want 0 1 1 %h",
                        obs_req_seen, obs_mis, obs_stall, obs_data, exp_lsu_data);
    end
`else
    exp_lsu_data = 32'h0BAD_F00D;
    n_cmp++;
    if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_mis !== 1'b0 || obs_data !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL misalign_truncate: got addr=%h be=%b mis=%b data=%h, want 00000100 1111 0 0badf00d",
                        obs_addr, obs_be, obs_mis, obs_data);
    end
`endif
  endtask

  task automatic test_timeout();
    n_cmp++;
    if (exp_lsu_data == 32'd0 || lsu_data_o !== exp_lsu_data) begin
      n_bad++; $display("FAIL timeout_precondition: got %h, want nonzero %h", lsu_data_o, exp_lsu_data);
    end
    run_access(1'b0, 3'd2, 32'h400, 32'h0, 32'h1111_1111, -1, 0);
    exp_lsu_data = 32'd0;
    n_cmp++;
    if (!obs_done || obs_req_cycles != TMO || obs_stall != TMO + 1) begin
      n_bad++; $display("FAIL timeout_len: got req_cycles=%0d stall=%0d done=%0b, want %0d %0d 1",
                        obs_req_cycles, obs_stall, obs_done, TMO, TMO + 1);
    end
    n_cmp++;
    if (obs_err !== 1'b1 || obs_data !== 32'd0 || obs_spurious != 0) begin
      n_bad++; $display("FAIL timeout_err: got err=%b data=%h spurious=%0d, want 1 0 0",
                        obs_err, obs_data, obs_spurious);
    end
    @(posedge clk_i); #2;
    n_cmp++;
    if (bus_err_o !== 1'b0 || lsu_stall_o !== 1'b0 || data_req_o !== 1'b0) begin
      n_bad++; $display("FAIL timeout_single_pulse: got err=%b stall=%b req=%b, want 0 0 0",
                        bus_err_o, lsu_stall_o, data_req_o);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk_i); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h300;
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    #1;
    n_cmp++;
    if (data_req_o !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_req: got %b, want 1", data_req_o);
    end
    @(posedge clk_i); #1;
    data_gnt_i = 1'b0;
    #1;
    n_cmp++;
    if (lsu_stall_o !== 1'b1 || data_req_o !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_wait: got stall=%b req=%b, want 1 0", lsu_stall_o, data_req_o);
    end
    rst_i = 1'b1;
    #1;
    exp_lsu_data = 32'd0;
    n_cmp++;
    if ({lsu_data_o, lsu_stall_o, bus_err_o, misalign_o, data_req_o, data_we_o,
         data_be_o, data_addr_o, data_wdata_o} !== 105'd0) begin
      n_bad++; $display("FAIL rstmid_async: got stall=%b req=%b be=%b addr=%h, want all 0",
                        lsu_stall_o, data_req_o, data_be_o, data_addr_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h55AA_55AA;
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
    #1;
    n_cmp++;
    if (lsu_data_o !== 32'd0 || lsu_stall_o !== 1'b0 || data_req_o !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_late_rvalid: got data=%h stall=%b req=%b, want 0 0 0",
                        lsu_data_o, lsu_stall_o, data_req_o);
    end
    run_access(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 0);
    exp_lsu_data = 32'hCAFE_F00D;
    n_cmp++;
    if (obs_data !== 32'hCAFE_F00D || obs_stall != 3) begin
      n_bad++; $display("FAIL rstmid_recover: got data=%h stall=%0d, want cafef00d 3", obs_data, obs_stall);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 60; i++) begin
      logic        we    = 1'($urandom);
      logic [2:0]  size  = 3'($urandom);
      logic [31:0] addr  = $urandom;
      logic [31:0] wd    = $urandom;
      logic [31:0] rd    = $urandom;
      int          gd    = int'($urandom_range(0, 2));
      int          rv    = int'($urandom_range(0, 2));
      bit          trap  = trapped(size, addr);
      int          exp_stall = trap ? 1 : gd + rv + 3;
      run_access(we, size, addr, wd, rd, gd, rv);
      if (!trap && !we) exp_lsu_data = m_load(size, addr, rd);
      n_cmp++;
      if (!obs_done || obs_stall != exp_stall || obs_spurious != 0) begin
        n_bad++; $display("FAIL rand%0d_stall: got %0d (done=%0b spurious=%0d), want %0d",
                          i, obs_stall, obs_done, obs_spurious, exp_stall);
      end
      n_cmp++;
      if (obs_data !== exp_lsu_data || obs_err !== 1'b0 || obs_mis !== trap) begin
        n_bad++; $display("FAIL rand%0d_result: got data=%h err=%b mis=%b, want %h 0 %b",
                          i, obs_data, obs_err, obs_mis, exp_lsu_data, trap);
      end
      if (!trap) begin
        n_cmp++;
        if (obs_be !== m_be(size, addr) || obs_addr !== {addr[31:2], 2'b00} || obs_we !== we ||
            (we && obs_wdata !== m_wdata(size, wd))) begin
          n_bad++; $display("FAIL rand%0d_bus: got be=%b addr=%h we=%b wdata=%h, want %b %h %b %h (size=%0d)",
                            i, obs_be, obs_addr, obs_we, obs_wdata, m_be(size, addr),
                            {addr[31:2], 2'b00}, we, m_wdata(size, wd), size);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_best_case();
    test_lb_lbu();
    test_sh();
    test_misaligned_lw();
    test_timeout();
    test_reset_mid();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
